// File: rtl/dyn_bcd_counter_disp_if.sv
// Board-side bundle for the BCD counter/display: control inputs, count/wrap status and display pins.
interface dyn_bcd_counter_disp_if #(
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned CNT_DIGITS = 4
);
    logic                    preset;
    logic [4*CNT_DIGITS-1:0] preset_val;
    logic                    up_down;
    logic                    run;
    logic                    blank_lz;
    logic [4*CNT_DIGITS-1:0] count;
    logic                    wrap;
    logic [DIGITS-1:0]       seg_sel;
    logic [7:0]              seg_led;

    modport master (
        output preset, preset_val, up_down, run, blank_lz,
        input  count, wrap, seg_sel, seg_led
    );

    modport slave (
        input  preset, preset_val, up_down, run, blank_lz,
        output count, wrap, seg_sel, seg_led
    );
endinterface

// File: rtl/dyn_bcd_counter_disp.sv
// BCD up/down counter with clamped preset, wrap flag and a multiplexed 7-segment scan
// with optional leading-zero blanking.
module dyn_bcd_counter_disp #(
    parameter int unsigned DIGITS            = 6,
    parameter int unsigned CNT_DIGITS        = 4,
    parameter int unsigned DIVCLK_CNTMAX_1ms = 49999,
    parameter int unsigned DIVCLK_CNTMAX_1s  = 999
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    dyn_bcd_counter_disp_if.slave    bus
);

    localparam int unsigned CNT_W  = 4 * CNT_DIGITS;
    localparam int unsigned MS_W   = (DIVCLK_CNTMAX_1ms > 0) ? $clog2(DIVCLK_CNTMAX_1ms + 1) : 1;
    localparam int unsigned S_W    = (DIVCLK_CNTMAX_1s > 0) ? $clog2(DIVCLK_CNTMAX_1s + 1) : 1;
    localparam int unsigned SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [MS_W-1:0]   ms_cnt;
    logic [S_W-1:0]    s_cnt;
    logic [SCAN_W-1:0] scan_idx;
    logic [CNT_W-1:0]  count_q;
    logic              wrap_q;
    logic [DIGITS-1:0] seg_sel_q;
    logic [7:0]        seg_led_q;

    logic              ms_tick_c;
    logic              s_tick_c;
    logic [CNT_W-1:0]  preset_clamped_c;
    logic [CNT_W-1:0]  step_c;
    logic              step_wrap_c;
    logic [SCAN_W-1:0] msnz_c;
    logic [3:0]        cur_digit_c;
    logic              cur_blank_c;

    // Active-low segment pattern for one BCD digit; dp always off.
    function automatic logic [7:0] seg_decode(input logic [3:0] d, input logic blank);
        logic [7:0] seg;
        seg = 8'hFF;
        if (!blank) begin
            case (d)
                4'd0:    seg = 8'hC0;
                4'd1:    seg = 8'hF9;
                4'd2:    seg = 8'hA4;
                4'd3:    seg = 8'hB0;
                4'd4:    seg = 8'h99;
                4'd5:    seg = 8'h92;
                4'd6:    seg = 8'h82;
                4'd7:    seg = 8'hF8;
                4'd8:    seg = 8'h80;
                4'd9:    seg = 8'h90;
                default: seg = 8'hFF;
            endcase
        end
        return seg;
    endfunction

    assign ms_tick_c = (ms_cnt == MS_W'(DIVCLK_CNTMAX_1ms));
    assign s_tick_c  = ms_tick_c && (s_cnt == S_W'(DIVCLK_CNTMAX_1s));

    // Preset clamp and ripple BCD step; carry out of the top digit is the wrap.
    always_comb begin
        logic [3:0] nib;
        logic [3:0] d;
        logic       carry;
        preset_clamped_c = '0;
        step_c           = count_q;
        nib              = 4'd0;
        d                = 4'd0;
        carry            = 1'b1;
        for (int i = 0; i < int'(CNT_DIGITS); i++) begin
            nib = bus.preset_val[4*i +: 4];
            preset_clamped_c[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
            d = count_q[4*i +: 4];
            if (carry) begin
                if (bus.up_down) begin
                    if (d >= 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            step_c[4*i +: 4] = d;
        end
        step_wrap_c = carry;
    end

    // Most-significant nonzero digit (0 when the count is zero) and the digit at the scan position.
    always_comb begin
        msnz_c      = '0;
        cur_digit_c = 4'd0;
        cur_blank_c = 1'b1;
        for (int i = 0; i < int'(CNT_DIGITS); i++) begin
            if (count_q[4*i +: 4] != 4'd0) begin
                msnz_c = SCAN_W'(i);
            end
        end
        for (int i = 0; i < int'(CNT_DIGITS); i++) begin
            if (scan_idx == SCAN_W'(i)) begin
                cur_digit_c = count_q[4*i +: 4];
                cur_blank_c = bus.blank_lz && (SCAN_W'(i) > msnz_c);
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            ms_cnt    <= '0;
            s_cnt     <= '0;
            scan_idx  <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            seg_sel_q <= '1;
            seg_led_q <= 8'hFF;
        end else begin
            ms_cnt <= ms_tick_c ? '0 : ms_cnt + 1'b1;
            if (ms_tick_c) begin
                s_cnt    <= s_tick_c ? '0 : s_cnt + 1'b1;
                scan_idx <= (scan_idx == SCAN_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end

            // Preset restarts the 1 s interval so the next step lands a full period later.
            if (bus.preset) begin
                count_q <= preset_clamped_c;
                ms_cnt  <= '0;
                s_cnt   <= '0;
                wrap_q  <= 1'b0;
            end else if (s_tick_c && bus.run) begin
                count_q <= step_c;
                wrap_q  <= step_wrap_c;
            end else begin
                wrap_q  <= 1'b0;
            end

            seg_sel_q <= ~(DIGITS'(1) << scan_idx);
            seg_led_q <= seg_decode(cur_digit_c, cur_blank_c);
        end
    end

    assign bus.count   = count_q;
    assign bus.wrap    = wrap_q;
    assign bus.seg_sel = seg_sel_q;
    assign bus.seg_led = seg_led_q;

endmodule
